// File: rtl/tanh_grad.sv
// rtl/tanh_grad.sv - backward-pass gradient delta = err * f'(y) for tanh/sigmoid, 3-stage valid/ready pipeline
module tanh_grad #(
    parameter int FEATURE_WIDE = 4,
    parameter int NUM_NEURON   = 16
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           flush,
    input  logic                           choice,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic signed [FEATURE_WIDE+15:0] y_in,
    input  logic signed [FEATURE_WIDE+15:0] err_in,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic signed [FEATURE_WIDE+15:0] delta_out,
    output logic                           layer_done
);
    localparam int D  = FEATURE_WIDE + 16;
    localparam int CW = $clog2(NUM_NEURON + 1);
    localparam logic [CW-1:0]       LAST    = CW'(NUM_NEURON - 1);
    localparam logic signed [D-1:0] ONE     = D'(64);
    localparam logic signed [D-1:0] NEG_ONE = -D'(64);

    logic                  r_v1, r_v2, r_v3;
    logic signed [D-1:0]   r_y1, r_e1, r_e2, r_d3;
    logic                  r_c1;
    logic [6:0]            r_g2;
    logic [CW-1:0]         r_count;
    logic                  r_done;

    logic                  w_adv;
    logic signed [D-1:0]   w_y_clamp;
    logic signed [D-1:0]   w_b_d;
    logic signed [2*D-1:0] w_a, w_b, w_prod;
    logic [6:0]            w_g;
    logic signed [D+7:0]   w_e_ext, w_g_ext, w_dprod;
    logic                  w_unused;

    assign w_adv      = !r_v3 || out_ready;
    assign in_ready   = w_adv;
    assign out_valid  = r_v3;
    assign delta_out  = r_d3;
    assign layer_done = r_done;

    always_comb begin
        w_y_clamp = y_in;
        if (choice) begin
            if (y_in < 0)        w_y_clamp = '0;
            else if (y_in > ONE) w_y_clamp = ONE;
        end else begin
            if (y_in < NEG_ONE)  w_y_clamp = NEG_ONE;
            else if (y_in > ONE) w_y_clamp = ONE;
        end
    end

    // One shared multiplier: y*y for tanh, y*(64-y) for sigmoid; both products are non-negative.
    assign w_b_d  = r_c1 ? (ONE - r_y1) : r_y1;
    assign w_a    = {{D{r_y1[D-1]}}, r_y1};
    assign w_b    = {{D{w_b_d[D-1]}}, w_b_d};
    assign w_prod = w_a * w_b;
    assign w_g    = r_c1 ? w_prod[12:6] : (7'd64 - w_prod[12:6]);

    // g <= 64 keeps |delta| within |err|+1, so truncating back to D bits needs no saturation.
    assign w_e_ext = {{8{r_e2[D-1]}}, r_e2};
    assign w_g_ext = {{(D+1){1'b0}}, r_g2};
    assign w_dprod = w_e_ext * w_g_ext;

    assign w_unused = ^{w_prod[2*D-1:13], w_prod[5:0], w_dprod[D+7:D+6], w_dprod[5:0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v1    <= 1'b0;
            r_v2    <= 1'b0;
            r_v3    <= 1'b0;
            r_y1    <= '0;
            r_e1    <= '0;
            r_c1    <= 1'b0;
            r_g2    <= '0;
            r_e2    <= '0;
            r_d3    <= '0;
            r_count <= '0;
            r_done  <= 1'b0;
        end else begin
            if (flush) begin
                r_v1    <= 1'b0;
                r_v2    <= 1'b0;
                r_v3    <= 1'b0;
                r_count <= '0;
                r_done  <= 1'b0;
            end else begin
                r_done <= 1'b0;
                if (r_v3 && out_ready) begin
                    if (r_count == LAST) begin
                        r_count <= '0;
                        r_done  <= 1'b1;
                    end else begin
                        r_count <= r_count + CW'(1);
                    end
                end
                if (w_adv) begin
                    r_v1 <= in_valid;
                    r_v2 <= r_v1;
                    r_v3 <= r_v2;
                end
            end
            if (w_adv) begin
                r_y1 <= w_y_clamp;
                r_e1 <= err_in;
                r_c1 <= choice;
                r_g2 <= w_g;
                r_e2 <= r_e1;
                r_d3 <= w_dprod[D+5:6];
            end
        end
    end
endmodule

// File: tb/tb_tanh_grad.sv
// tb/tb_tanh_grad.sv - randomized self-checking bench for tanh_grad against an arithmetic reference model
module tb_tanh_grad;
    localparam int D = 20;

    logic clk = 1'b0;
    logic rst_n, flush, choice, in_valid, in_ready, out_valid, out_ready, layer_done;
    logic signed [D-1:0] y_in, err_in, delta_out;

    int n_tests = 0;
    int n_fail  = 0;
    logic signed [D-1:0] got_q[$];
    logic signed [D-1:0] exp_q[$];
    int done_at[$];
    int xfer_total = 0;

    always #5 clk = ~clk;

    tanh_grad #(.FEATURE_WIDE(4), .NUM_NEURON(4)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .choice(choice),
        .in_valid(in_valid), .in_ready(in_ready), .y_in(y_in), .err_in(err_in),
        .out_valid(out_valid), .out_ready(out_ready), .delta_out(delta_out),
        .layer_done(layer_done)
    );

    always @(posedge clk) begin
        if (rst_n && !flush) begin
            if (layer_done) done_at.push_back(xfer_total);
            if (out_valid && out_ready) begin
                got_q.push_back(delta_out);
                xfer_total++;
            end
        end
    end

    function automatic logic signed [D-1:0] model(int y, int e, bit c);
        int yc, g, p, q;
        yc = y;
        if (c) begin
            if (yc < 0)  yc = 0;
            if (yc > 64) yc = 64;
            g = (yc * (64 - yc)) / 64;
        end else begin
            if (yc < -64) yc = -64;
            if (yc > 64)  yc = 64;
            g = 64 - (yc * yc) / 64;
        end
        p = e * g;
        q = p / 64;
        if (p < 0 && (p % 64) != 0) q = q - 1;
        return D'(q);
    endfunction

    function automatic int rand_y();
        return int'($urandom_range(400)) - 200;
    endfunction

    function automatic int rand_e();
        return int'($urandom_range(262144)) - 131072;
    endfunction

    task automatic drive(int y, int e, bit c);
        int guard;
        @(negedge clk);
        y_in = D'(y); err_in = D'(e); choice = c; in_valid = 1'b1;
        #2;
        guard = 0;
        while (!in_ready && guard < 100) begin
            @(negedge clk); #2; guard++;
        end
        n_tests++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL drive_accept: in_ready=%0b required=1", in_ready);
        end
        @(posedge clk);
        exp_q.push_back(model(y, e, c));
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_got(int base, int n);
        int guard;
        guard = 0;
        while (got_q.size() < base + n && guard < 200) begin
            @(negedge clk); guard++;
        end
        n_tests++;
        if (got_q.size() != base + n) begin
            n_fail++;
            $display("FAIL output_count: got %0d required %0d", got_q.size() - base, n);
        end
    endtask

    task automatic time_one(int y, int e, bit c, output int lat, output logic signed [D-1:0] v);
        out_ready = 1'b1;
        @(negedge clk);
        y_in = D'(y); err_in = D'(e); choice = c; in_valid = 1'b1;
        lat = 0;
        v = '0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            if (out_valid) begin
                lat = i;
                v = delta_out;
                break;
            end
        end
    endtask

    task automatic compare_stream(string name, int bg, int be, int n);
        for (int i = 0; i < n; i++) begin
            n_tests++;
            if (bg + i >= got_q.size() || be + i >= exp_q.size()) begin
                n_fail++;
                $display("FAIL %s[%0d]: output missing", name, i);
            end else if (got_q[bg+i] !== exp_q[be+i]) begin
                n_fail++;
                $display("FAIL %s[%0d]: got %0d required %0d", name, i, got_q[bg+i], exp_q[be+i]);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        choice = 1'b0; y_in = '0; err_in = '0;
        repeat (3) @(negedge clk);
        n_tests += 5;
        if (in_ready !== 1'b1)   begin n_fail++; $display("FAIL reset_in_ready: got %0b required 1", in_ready); end
        if (out_valid !== 1'b0)  begin n_fail++; $display("FAIL reset_out_valid: got %0b required 0", out_valid); end
        if (delta_out !== '0)    begin n_fail++; $display("FAIL reset_delta: got %0d required 0", delta_out); end
        if (layer_done !== 1'b0) begin n_fail++; $display("FAIL reset_layer_done: got %0b required 0", layer_done); end
        if (dut.r_count !== '0)  begin n_fail++; $display("FAIL reset_count: got %0d required 0", dut.r_count); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_latency();
        int lat;
        logic signed [D-1:0] v;
        time_one(0, 64, 1'b0, lat, v);
        n_tests += 2;
        if (lat != 3)   begin n_fail++; $display("FAIL latency: got %0d required 3", lat); end
        if (v !== 20'sd64) begin n_fail++; $display("FAIL latency_value: got %0d required 64", v); end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_tanh();
        int bg, be;
        bg = got_q.size(); be = exp_q.size();
        out_ready = 1'b1;
        drive(32, 64, 1'b0);
        drive(100, 64, 1'b0);
        drive(-32, -1, 1'b0);
        for (int i = 0; i < 20; i++) drive(rand_y(), rand_e(), 1'b0);
        idle();
        wait_got(bg, 23);
        if (got_q.size() >= bg + 3) begin
            n_tests += 3;
            if (got_q[bg]   !== 20'sd48) begin n_fail++; $display("FAIL tanh_y32: got %0d required 48", got_q[bg]); end
            if (got_q[bg+1] !== 20'sd0)  begin n_fail++; $display("FAIL tanh_clamp: got %0d required 0", got_q[bg+1]); end
            if (got_q[bg+2] !== -20'sd1) begin n_fail++; $display("FAIL tanh_floor: got %0d required -1", got_q[bg+2]); end
        end
        compare_stream("tanh_rand", bg, be, 23);
    endtask

    task automatic test_sigmoid();
        int bg, be;
        bg = got_q.size(); be = exp_q.size();
        out_ready = 1'b1;
        drive(32, -128, 1'b1);
        drive(-20, 100, 1'b1);
        drive(64, 64, 1'b1);
        for (int i = 0; i < 20; i++) drive(rand_y(), rand_e(), 1'b1);
        for (int i = 0; i < 10; i++) drive(rand_y(), rand_e(), i[0]);
        idle();
        wait_got(bg, 33);
        if (got_q.size() >= bg + 3) begin
            n_tests += 3;
            if (got_q[bg]   !== -20'sd32) begin n_fail++; $display("FAIL sig_y32: got %0d required -32", got_q[bg]); end
            if (got_q[bg+1] !== 20'sd0)   begin n_fail++; $display("FAIL sig_clamp: got %0d required 0", got_q[bg+1]); end
            if (got_q[bg+2] !== 20'sd0)   begin n_fail++; $display("FAIL sig_y64: got %0d required 0", got_q[bg+2]); end
        end
        compare_stream("sig_rand", bg, be, 33);
    endtask

    task automatic test_stall();
        int bg, be, stalls;
        logic signed [D-1:0] held;
        bit have;
        bg = got_q.size(); be = exp_q.size();
        have = 1'b0; stalls = 0; held = '0;
        out_ready = 1'b1;
        fork
            begin
                for (int i = 0; i < 8; i++) drive(rand_y(), rand_e(), i[1]);
                idle();
            end
            begin
                for (int c = 0; c < 30; c++) begin
                    @(negedge clk);
                    out_ready = !(c >= 2 && c <= 6);
                    #1;
                    if (!out_ready && out_valid) begin
                        stalls++;
                        n_tests++;
                        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_in_ready: got %0b required 0", in_ready); end
                        if (have) begin
                            n_tests++;
                            if (delta_out !== held) begin n_fail++; $display("FAIL stall_hold: got %0d required %0d", delta_out, held); end
                        end
                        held = delta_out;
                        have = 1'b1;
                    end
                end
            end
        join
        n_tests++;
        if (stalls != 4) begin n_fail++; $display("FAIL stall_cycles: got %0d required 4", stalls); end
        out_ready = 1'b1;
        wait_got(bg, 8);
        compare_stream("stall_order", bg, be, 8);
    endtask

    task automatic test_back_to_back();
        int bg, be, bd, bx;
        @(negedge clk); flush = 1'b1;
        @(negedge clk); flush = 1'b0;
        bg = got_q.size(); be = exp_q.size(); bd = done_at.size(); bx = xfer_total;
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) drive(rand_y(), rand_e(), $urandom_range(1) == 1);
        idle();
        wait_got(bg, 10);
        repeat (3) @(negedge clk);
        n_tests += 2;
        if (done_at.size() - bd != 2) begin
            n_fail++; $display("FAIL layer_pulses: got %0d required 2", done_at.size() - bd);
        end else begin
            if (done_at[bd] != bx + 4 || done_at[bd+1] != bx + 8) begin
                n_fail++;
                $display("FAIL layer_timing: got %0d,%0d required 4,8", done_at[bd] - bx, done_at[bd+1] - bx);
            end
        end
        n_tests++;
        if (dut.r_count !== 3'd2) begin n_fail++; $display("FAIL layer_count: got %0d required 2", dut.r_count); end
        if (done_at.size() - bd != 2) n_fail++;
        compare_stream("b2b", bg, be, 10);
    endtask

    task automatic test_flush();
        int bg, lat, y, e;
        bit seen;
        logic signed [D-1:0] v;
        bg = got_q.size();
        out_ready = 1'b1;
        drive(rand_y(), rand_e(), 1'b0);
        drive(rand_y(), rand_e(), 1'b1);
        @(negedge clk);
        flush = 1'b1;
        y_in = D'(rand_y()); err_in = D'(rand_e()); in_valid = 1'b1;
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        #1;
        n_tests += 3;
        if (out_valid !== 1'b0)  begin n_fail++; $display("FAIL flush_out_valid: got %0b required 0", out_valid); end
        if (dut.r_count !== '0)  begin n_fail++; $display("FAIL flush_count: got %0d required 0", dut.r_count); end
        if (layer_done !== 1'b0) begin n_fail++; $display("FAIL flush_layer_done: got %0b required 0", layer_done); end
        seen = 1'b0;
        repeat (5) begin @(negedge clk); if (out_valid) seen = 1'b1; end
        n_tests++;
        if (seen || got_q.size() != bg) begin n_fail++; $display("FAIL flush_discard: got %0d outputs required 0", got_q.size() - bg); end
        y = rand_y(); e = rand_e();
        time_one(y, e, 1'b0, lat, v);
        n_tests += 2;
        if (lat != 3) begin n_fail++; $display("FAIL flush_relatency: got %0d required 3", lat); end
        if (v !== model(y, e, 1'b0)) begin n_fail++; $display("FAIL flush_value: got %0d required %0d", v, model(y, e, 1'b0)); end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int bg, lat, guard, y, e;
        logic signed [D-1:0] v;
        bg = got_q.size();
        out_ready = 1'b1;
        drive(rand_y(), rand_e(), 1'b1);
        idle();
        wait_got(bg, 1);
        @(negedge clk); out_ready = 1'b0;
        drive(rand_y(), rand_e(), 1'b0);
        drive(rand_y(), rand_e(), 1'b1);
        idle();
        guard = 0;
        while (!out_valid && guard < 20) begin @(negedge clk); guard++; end
        #2;
        rst_n = 1'b0;
        #1;
        n_tests += 5;
        if (out_valid !== 1'b0)  begin n_fail++; $display("FAIL rst_mid_out_valid: got %0b required 0", out_valid); end
        if (delta_out !== '0)    begin n_fail++; $display("FAIL rst_mid_delta: got %0d required 0", delta_out); end
        if (in_ready !== 1'b1)   begin n_fail++; $display("FAIL rst_mid_in_ready: got %0b required 1", in_ready); end
        if (layer_done !== 1'b0) begin n_fail++; $display("FAIL rst_mid_layer_done: got %0b required 0", layer_done); end
        if (dut.r_count !== '0)  begin n_fail++; $display("FAIL rst_mid_count: got %0d required 0", dut.r_count); end
        @(negedge clk);
        rst_n = 1'b1;
        y = rand_y(); e = rand_e();
        time_one(y, e, 1'b1, lat, v);
        n_tests += 2;
        if (lat != 3) begin n_fail++; $display("FAIL rst_relatency: got %0d required 3", lat); end
        if (v !== model(y, e, 1'b1)) begin n_fail++; $display("FAIL rst_value: got %0d required %0d", v, model(y, e, 1'b1)); end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_tanh();
        test_sigmoid();
        test_stall();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
